tristate_bus_arbiter: RTL

Round-robin arbiter and sequencer for a shared multi-driver bus. It grants exactly one of N requesters the right to drive the shared net at a time, and inserts a turnaround gap of all-released cycles between owners, so that two drivers never resolve to X. It sits beside the shared bus. Its per-requester `drive_en` outputs gate each requester's continuous-assign tri-state driver (`drive_en ? data : 'z`). It also enforces a maximum hold time per grant.

---
 rtl/tristate_bus_arbiter_if.sv | 41 ++++
 rtl/tristate_bus_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter_if : request/grant bundle between arbiter and requesters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tristate_bus_arbiter_if #(
   parameter int N = 4
);
   localparam int OW = $clog2(N);

   logic [N-1:0]  req;
   logic [N-1:0]  done;
   logic [N-1:0]  grant;
   logic [N-1:0]  drive_en;
   logic [OW-1:0] bus_owner;
   logic          bus_busy;
   logic          timeout;

   modport master (
      input  req,
      input  done,
      output grant,
      output drive_en,
      output bus_owner,
      output bus_busy,
      output timeout
   );

   modport slave (
      output req,
      output done,
      input  grant,
      input  drive_en,
      input  bus_owner,
      input  bus_busy,
      input  timeout
   );
endinterface

`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter : round-robin owner sequencer with turnaround and hold limit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tristate_bus_arbiter #(
   parameter int N           = 4,
   parameter int MAX_HOLD    = 8,
   parameter int TURN_CYCLES = 1
) (
   input  wire                    clk,
   input  wire                    rst_n,
   tristate_bus_arbiter_if.master bus
);
   localparam int OW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam int TW = $clog2(TURN_CYCLES + 1);

   localparam logic [HW-1:0] C_MAX_HOLD = HW'(MAX_HOLD);
   localparam logic [TW-1:0] C_TURN     = TW'(TURN_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t        r_state;
   logic [N-1:0]  r_grant;
   logic [OW-1:0] r_owner;
   logic [OW-1:0] r_last_owner;
   logic [HW-1:0] r_hold;
   logic [TW-1:0] r_turn;
   logic          r_timeout;

   logic [OW-1:0] w_idx;
   logic [OW-1:0] w_win;
   logic          w_win_valid;
   logic [N-1:0]  w_win_onehot;
   logic          w_owner_done;
   logic          w_owner_req;
   logic          w_expire;
   logic          w_release;

   // Scan from the farthest offset down so the nearest requester after
   // last_owner is written last; last_owner itself is offset N, hence lowest priority.
   always_comb begin
      w_idx       = '0;
      w_win       = r_last_owner;
      w_win_valid = 1'b0;
      for (int i = N; i >= 1; i--) begin
         w_idx = OW'((int'(r_last_owner) + i) % N);
         if (bus.req[w_idx]) begin
            w_win       = w_idx;
            w_win_valid = 1'b1;
         end
      end
   end

   assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;
   assign w_owner_done = bus.done[r_owner];
   assign w_owner_req  = bus.req[r_owner];
   assign w_expire     = (r_hold == C_MAX_HOLD);
   assign w_release    = w_owner_done | ~w_owner_req | w_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_owner      <= '0;
         r_last_owner <= OW'(N - 1);
         r_hold       <= '0;
         r_turn       <= '0;
         r_timeout    <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_win_valid) begin
                  r_state      <= GRANT;
                  r_grant      <= w_win_onehot;
                  r_owner      <= w_win;
                  r_last_owner <= w_win;
                  r_hold       <= HW'(1);
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_state   <= TURN;
                  r_grant   <= '0;
                  r_hold    <= '0;
                  r_turn    <= TW'(1);
                  // A voluntary release in the same cycle as expiry is not a timeout.
                  r_timeout <= w_expire & ~w_owner_done & w_owner_req;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            TURN: begin
               if (r_turn == C_TURN) begin
                  r_turn <= '0;
                  if (w_win_valid) begin
                     r_state      <= GRANT;
                     r_grant      <= w_win_onehot;
                     r_owner      <= w_win;
                     r_last_owner <= w_win;
                     r_hold       <= HW'(1);
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_turn <= r_turn + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

   assign bus.grant     = r_grant;
   assign bus.drive_en  = r_grant;
   assign bus.bus_owner = r_owner;
   assign bus.bus_busy  = (r_state == GRANT);
   assign bus.timeout   = r_timeout;

endmodule

`default_nettype wire
